// File: rtl/period_meter_if.sv
// Signal bundle for period_meter: the measured input and the measurement results.
// master = the meter (drives the results), slave = whoever supplies sig_in and reads results.
interface period_meter_if #(
    parameter int W = 32
);
    logic         sig_in;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         meas_valid;
    logic         stalled;
    logic         level;

    modport master (
        input  sig_in,
        output period, high_time, meas_valid, stalled, level
    );

    modport slave (
        output sig_in,
        input  period, high_time, meas_valid, stalled, level
    );
endinterface

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles, with stall detect.
// Optional `define PERIOD_METER_AVG_EN reports a 4-period running mean instead of raw values.
module period_meter #(
    parameter int W       = 32,
    parameter int TIMEOUT = 200_000_000
) (
    input  logic           clk,
    input  logic           rst,
    period_meter_if.master pm
);
    localparam logic [W-1:0] RC_MAX  = '1;
    localparam logic [W-1:0] TO_LAST = W'(TIMEOUT - 1);

    typedef enum logic [1:0] {SEEK, ARMED, RUN} state_t;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v == RC_MAX) ? v : v + 1'b1;
    endfunction

    logic         s0, s1, s2;
    logic         rise_p0, fall_p0;
    logic [W-1:0] rc, hc, rc_inc;
    logic         capture, stall_set, stall_clr, timeout_hit;
    state_t       state_q, state_d;

    // Synchronizer, edge-detect delay flop and registered edge strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            s0      <= 1'b0;
            s1      <= 1'b0;
            s2      <= 1'b0;
            rise_p0 <= 1'b0;
            fall_p0 <= 1'b0;
        end else begin
            s0      <= pm.sig_in;
            s1      <= s0;
            s2      <= s1;
            rise_p0 <= s1 & ~s2;
            fall_p0 <= ~s1 & s2;
        end
    end

    assign pm.level    = s1;
    assign rc_inc      = sat_inc(rc);
    assign timeout_hit = (rc == TO_LAST) && !rise_p0;

    always_ff @(posedge clk) begin
        if (rst) state_q <= SEEK;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        stall_set = 1'b0;
        stall_clr = 1'b0;
        case (state_q)
            SEEK: begin
                if (rise_p0) begin
                    state_d   = ARMED;
                    stall_clr = 1'b1;
                end
            end
            ARMED, RUN: begin
                if (rise_p0) begin
                    state_d = RUN;
                    capture = 1'b1;
                end else if (timeout_hit) begin
                    state_d   = SEEK;
                    stall_set = 1'b1;
                end
            end
            default: state_d = SEEK;
        endcase
    end

    // Interval counter, high-time latch and stall flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rc         <= '0;
            hc         <= '0;
            pm.stalled <= 1'b0;
        end else begin
            rc <= rise_p0 ? '0 : rc_inc;
            if (fall_p0) hc <= rc_inc;
            if (stall_set)      pm.stalled <= 1'b1;
            else if (stall_clr) pm.stalled <= 1'b0;
        end
    end

`ifdef PERIOD_METER_AVG_EN
    function automatic logic [W-1:0] avg4(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c, input logic [W-1:0] d);
        logic [W+1:0] sum;
        sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
        return sum[W+1:2];
    endfunction

    logic [W-1:0] per_win [3];
    logic [W-1:0] hi_win  [3];
    logic [2:0]   fill;

    // Window data needs no reset: fill count alone decides when it is trusted
    always_ff @(posedge clk) begin
        if (capture) begin
            per_win[0] <= rc_inc;
            per_win[1] <= per_win[0];
            per_win[2] <= per_win[1];
            hi_win[0]  <= hc;
            hi_win[1]  <= hi_win[0];
            hi_win[2]  <= hi_win[1];
        end
    end

    // Averaged output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            fill          <= '0;
            pm.period     <= '0;
            pm.high_time  <= '0;
            pm.meas_valid <= 1'b0;
        end else begin
            pm.meas_valid <= 1'b0;
            if (stall_set) begin
                fill <= '0;
            end else if (capture) begin
                if (fill != 3'd4) fill <= fill + 3'd1;
                if (fill >= 3'd3) begin
                    pm.meas_valid <= 1'b1;
                    pm.period     <= avg4(rc_inc, per_win[0], per_win[1], per_win[2]);
                    pm.high_time  <= avg4(hc, hi_win[0], hi_win[1], hi_win[2]);
                end
            end
        end
    end
`else
    // Raw output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            pm.period     <= '0;
            pm.high_time  <= '0;
            pm.meas_valid <= 1'b0;
        end else begin
            pm.meas_valid <= capture;
            if (capture) begin
                pm.period    <= rc_inc;
                pm.high_time <= hc;
            end
        end
    end
`endif
endmodule
